// File: rtl/ptp_ram_pkg.sv
// ptp_ram_pkg: shared types and helpers for the PTP frame buffer read path
package ptp_ram_pkg;
    localparam int P_ADDR_W = 8;
    localparam int P_DATA_W = 32;
    localparam int P_RD_LAT = 2;
    localparam logic [10:0] MAX_LEN = 11'd1024;
    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} rd_state_t;
    typedef struct packed {
        logic [P_DATA_W-1:0] data;
        logic sop;
        logic eop;
        logic [1:0] empty;
    } beat_t;
    // {256 flag, 8-bit count} of words in a frame after clamping to 1024 bytes
    function automatic logic [8:0] frame_words(input logic [10:0] len);
        logic [10:0] lc;
        lc = len > MAX_LEN ? MAX_LEN : len;
        return 9'((lc + 11'd3) >> 2);
    endfunction
    function automatic logic [1:0] frame_empty(input logic [10:0] len);
        return len > MAX_LEN ? 2'd0 : 2'd0 - len[1:0];
    endfunction
endpackage

// File: rtl/ram_rd_skid_fifo.sv
// ram_rd_skid_fifo: small synchronous FIFO of beats absorbing RAM read latency under backpressure
module ram_rd_skid_fifo
    import ptp_ram_pkg::*;
#(
    parameter int DEPTH = P_RD_LAT + 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic flush,
    input  logic push,
    input  beat_t din,
    input  logic pop,
    output beat_t head,
    output logic [CW-1:0] count
);
    beat_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/ram_frame_reader.sv
// ram_frame_reader: replays a frame from the frame RAM as an Avalon-ST source with backpressure
module ram_frame_reader
    import ptp_ram_pkg::*;
#(
    parameter int ADDR_W = P_ADDR_W,
    parameter int DATA_W = P_DATA_W,
    parameter int RD_LAT = P_RD_LAT,
    parameter int FIFO_DEPTH = RD_LAT + 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [10:0] len_bytes,
    input  logic abort,
    output logic busy,
    output logic done,
    output logic [ADDR_W-1:0] ram_address,
    output logic ram_wren,
    output logic [3:0] ram_byteena,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] src_data,
    output logic src_valid,
    output logic src_sop,
    output logic src_eop,
    output logic [1:0] src_empty,
    input  logic src_ready
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    rd_state_t state;
    logic [8:0] rem;
    logic first;
    logic [1:0] last_empty;
    logic [RD_LAT-1:0] tag_v, tag_sop, tag_eop;
    logic [CW-1:0] fifo_count, inflight;
    logic issue, last_rd, pop, flush;
    beat_t head, din;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(tag_v[i]);
    end

    // reads already in flight reserve their FIFO slot, so nothing is ever dropped
    assign issue = state == READ && !abort && fifo_count + inflight < CW'(FIFO_DEPTH);
    assign last_rd = issue && rem == 9'd1;
    assign flush = abort && (state == READ || state == DRAIN);
    assign pop = src_valid && src_ready;
    assign din = '{data: ram_q, sop: tag_sop[RD_LAT-1], eop: tag_eop[RD_LAT-1],
                   empty: tag_eop[RD_LAT-1] ? last_empty : 2'd0};

    assign src_valid = fifo_count != '0;
    assign src_data = head.data;
    assign src_sop = src_valid && head.sop;
    assign src_eop = src_valid && head.eop;
    assign src_empty = src_valid ? head.empty : 2'd0;
    assign ram_wren = 1'b0;
    assign ram_byteena = 4'hF;

    ram_rd_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset_n(reset_n),
        .flush(flush),
        .push(tag_v[RD_LAT-1]),
        .din(din),
        .pop(pop),
        .head(head),
        .count(fifo_count)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            ram_address <= '0;
            rem <= '0;
            first <= 1'b0;
            last_empty <= 2'd0;
            tag_v <= '0;
            tag_sop <= '0;
            tag_eop <= '0;
        end else begin
            tag_v <= flush ? '0 : (tag_v << 1) | RD_LAT'(issue);
            tag_sop <= (tag_sop << 1) | RD_LAT'(issue && first);
            tag_eop <= (tag_eop << 1) | RD_LAT'(last_rd);
            if (issue) begin
                ram_address <= ram_address + ADDR_W'(1);
                rem <= rem - 9'd1;
                first <= 1'b0;
            end
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    ram_address <= start_addr;
                    rem <= frame_words(len_bytes);
                    last_empty <= frame_empty(len_bytes);
                    first <= 1'b1;
                    state <= len_bytes == 11'd0 ? DONE : READ;
                    done <= len_bytes == 11'd0;
                end
                READ: if (abort) begin
                    state <= DONE;
                    done <= 1'b1;
                    busy <= 1'b0;
                end else if (last_rd) state <= DRAIN;
                DRAIN: if (abort || (pop && head.eop)) begin
                    state <= DONE;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_frame_reader.sv
// tb_ram_frame_reader: vector table plus random frames against a word-level model of the replay
module tb_ram_frame_reader;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic src_ready = 1'b0;
    logic [7:0] start_addr = 8'd0;
    logic [10:0] len_bytes = 11'd0;
    logic busy, done, ram_wren, src_valid, src_sop, src_eop;
    logic [7:0] ram_address;
    logic [3:0] ram_byteena;
    logic [31:0] ram_q, src_data, p1;
    logic [1:0] src_empty;

    always #5 clock = ~clock;

    ram_frame_reader dut (
        .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .len_bytes(len_bytes), .abort(abort), .busy(busy), .done(done),
        .ram_address(ram_address), .ram_wren(ram_wren), .ram_byteena(ram_byteena),
        .ram_q(ram_q), .src_data(src_data), .src_valid(src_valid), .src_sop(src_sop),
        .src_eop(src_eop), .src_empty(src_empty), .src_ready(src_ready)
    );

    logic [31:0] mem [256];
    always @(posedge clock) begin
        p1 <= mem[ram_address];
        ram_q <= p1;
    end

    typedef struct {
        logic [31:0] data;
        logic sop;
        logic eop;
        logic [1:0] empty;
        int cyc;
    } beat_rec_t;
    typedef struct {
        logic [7:0] addr;
        int len;
        int words;
        int empty;
    } vec_t;

    beat_rec_t beats[$];
    int done_q[$];
    logic done_busy_q[$];
    int cyc = 0, total = 0, bad = 0, mode = 0;
    int adv = 0, acc = 0, viol = 0;
    logic prev_busy = 1'b0;
    logic [7:0] prev_addr = 8'd0;

    always @(negedge clock) begin
        if (busy && !prev_busy) begin
            adv = 0;
            acc = 0;
        end
        if (busy && prev_busy && ram_address == prev_addr + 8'd1) adv++;
        if (busy && adv - acc > DEPTH) viol++;
        if (src_valid && src_ready) begin
            beats.push_back('{src_data, src_sop, src_eop, src_empty, cyc});
            acc++;
        end
        if (done) begin
            done_q.push_back(cyc);
            done_busy_q.push_back(busy);
        end
        prev_busy = busy;
        prev_addr = ram_address;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        src_ready = mode == 1 ? 1'b1 : mode == 2 ? ($urandom_range(0, 99) < 30) : 1'b0;
    endtask

    function automatic int exp_words(input int len);
        int lc;
        lc = len > 1024 ? 1024 : len;
        return (lc + 3) / 4;
    endfunction

    function automatic int exp_empty(input int len);
        int lc;
        lc = len > 1024 ? 1024 : len;
        return (4 - lc % 4) % 4;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, src_valid, 0);
        check({tag, "_sop"}, src_sop, 0);
        check({tag, "_eop"}, src_eop, 0);
        check({tag, "_empty"}, src_empty, 0);
        check({tag, "_data"}, src_data, 0);
        check({tag, "_addr"}, ram_address, 0);
        check({tag, "_wren"}, ram_wren, 0);
        check({tag, "_byteena"}, ram_byteena, 4'hF);
    endtask

    task automatic run_frame(input logic [7:0] a, input int len, input int m, input int ew, input int ee);
        int b0, d0, v0, s, n, w, k;
        logic [1:0] e;
        mode = m;
        b0 = beats.size();
        d0 = done_q.size();
        v0 = viol;
        w = exp_words(len);
        tick();
        start = 1'b1;
        start_addr = a;
        len_bytes = 11'(len);
        s = cyc;
        tick();
        start = 1'b0;
        k = 0;
        while (done_q.size() == d0 && k < 6000) begin
            tick();
            k++;
        end
        check("done_seen", done_q.size() > d0, 1);
        tick();
        tick();
        n = beats.size() - b0;
        check("beat_count", n, ew);
        check("done_count", done_q.size() - d0, 1);
        for (int i = 0; i < n && i < w; i++) begin
            e = i == w - 1 ? 2'(exp_empty(len)) : 2'd0;
            check("beat", {beats[b0+i].data, beats[b0+i].sop, beats[b0+i].eop, beats[b0+i].empty},
                  {mem[8'(a + i)], i == 0, i == w - 1, e});
        end
        if (n > 0) begin
            check("last_empty", beats[b0+n-1].empty, ee);
            if (m == 1) begin
                check("first_valid_cycle", beats[b0].cyc - s, 4);
                check("eop_cycle", beats[b0+n-1].cyc - s, 3 + ew);
            end
            if (done_q.size() > d0) begin
                check("done_after_eop", done_q[d0] - beats[b0+n-1].cyc, 1);
                check("busy_at_done", done_busy_q[d0], 0);
            end
        end
        check("outstanding_bound", viol - v0, 0);
    endtask

    initial begin
        vec_t vecs[8];
        int b0, d0, len;
        logic [7:0] a;
        vecs[0] = '{8'h10, 64, 16, 0};
        vecs[1] = '{8'h20, 7, 2, 1};
        vecs[2] = '{8'h30, 1, 1, 3};
        vecs[3] = '{8'hFE, 16, 4, 0};
        vecs[4] = '{8'h00, 1024, 256, 0};
        vecs[5] = '{8'h80, 1023, 256, 1};
        vecs[6] = '{8'h44, 2047, 256, 0};
        vecs[7] = '{8'hF0, 5, 2, 3};
        for (int i = 0; i < 256; i++) mem[i] = $urandom;

        tick();
        tick();
        check_reset("reset");
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_frame(vecs[i].addr, vecs[i].len, 1, vecs[i].words, vecs[i].empty);

        // zero-length start
        mode = 1;
        b0 = beats.size();
        tick();
        start = 1'b1;
        start_addr = 8'h05;
        len_bytes = 11'd0;
        tick();
        start = 1'b0;
        check("zero_busy1", busy, 1);
        check("zero_done1", done, 1);
        tick();
        check("zero_busy2", busy, 0);
        check("zero_done2", done, 0);
        repeat (6) tick();
        check("zero_no_beats", beats.size() - b0, 0);

        // second start while busy is ignored
        b0 = beats.size();
        d0 = done_q.size();
        tick();
        start = 1'b1;
        start_addr = 8'h60;
        len_bytes = 11'd64;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        start_addr = 8'h90;
        len_bytes = 11'd40;
        tick();
        start = 1'b0;
        repeat (40) tick();
        check("busy_start_beats", beats.size() - b0, 16);
        check("busy_start_dones", done_q.size() - d0, 1);
        if (beats.size() - b0 == 16) check("busy_start_last", beats[b0+15].data, mem[8'h6F]);

        // abort in DRAIN with the sink stalled
        mode = 0;
        b0 = beats.size();
        d0 = done_q.size();
        tick();
        start = 1'b1;
        start_addr = 8'hA0;
        len_bytes = 11'd8;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("pre_abort_valid", src_valid, 1);
        check("pre_abort_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        mode = 1;
        check("abort_valid", src_valid, 0);
        check("abort_eop", src_eop, 0);
        check("abort_done", done, 1);
        tick();
        check("abort_busy", busy, 0);
        check("abort_done_end", done, 0);
        repeat (6) tick();
        check("abort_no_beats", beats.size() - b0, 0);
        check("abort_dones", done_q.size() - d0, 1);

        // abort in READ
        mode = 0;
        tick();
        start = 1'b1;
        start_addr = 8'h11;
        len_bytes = 11'd1024;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("abort_rd_pre_valid", src_valid, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_rd_valid", src_valid, 0);
        check("abort_rd_done", done, 1);
        tick();

        // reset mid-frame
        mode = 1;
        tick();
        start = 1'b1;
        start_addr = 8'h33;
        len_bytes = 11'd200;
        tick();
        start = 1'b0;
        repeat (8) tick();
        check("mid_pre_busy", busy, 1);
        reset_n = 1'b0;
        tick();
        check_reset("mid_reset");
        reset_n = 1'b1;
        b0 = beats.size();
        d0 = done_q.size();
        repeat (12) tick();
        check("mid_no_done", done_q.size() - d0, 0);
        check("mid_no_beats", beats.size() - b0, 0);

        // randomized frames under 30% ready
        run_frame(8'($urandom_range(0, 255)), 1024, 2, 256, 0);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(0, 255));
            len = $urandom_range(1, 1024);
            run_frame(a, len, 2, exp_words(len), exp_empty(len));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
